// File: rtl/dly_train_pkg.sv
// -----------------------------------------------------------------------------
// dly_train_pkg
// Shared definitions for the I/O delay-line training controller.
//   state_t   : training state machine encoding
//   tap_width : width of a tap index for a given number of taps
//   len_width : width able to hold a run length of 0..num_taps
// -----------------------------------------------------------------------------
package dly_train_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_STEP,
    ST_FINAL,
    ST_CLOAD,
    ST_CSTEP,
    ST_DONE
  } state_t;

  // A single tap still needs one bit so that port vectors never collapse.
  function automatic int tap_width(input int num_taps);
    return (num_taps < 2) ? 1 : $clog2(num_taps);
  endfunction

  function automatic int len_width(input int num_taps);
    return $clog2(num_taps + 1);
  endfunction

endpackage

// File: rtl/dly_window_tracker.sv
// -----------------------------------------------------------------------------
// dly_window_tracker
// Tracks the current run of good taps and the longest run seen so far.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   clear       : wipe both current and best runs (start of a sweep)
//   update      : score one tap; good says whether that tap passed
//   close       : end of sweep, fold any open run into the best
//   tap         : index of the tap being scored
//   best_start  : first tap of the longest run
//   best_len    : length of the longest run
// -----------------------------------------------------------------------------
module dly_window_tracker
  import dly_train_pkg::*;
#(
  parameter int NUM_TAPS = 128,
  localparam int TW = tap_width(NUM_TAPS),
  localparam int LW = len_width(NUM_TAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          update,
  input  logic          good,
  input  logic          close,
  input  logic [TW-1:0] tap,
  output logic [TW-1:0] best_start,
  output logic [LW-1:0] best_len
);

  logic [TW-1:0] cur_start;
  logic [LW-1:0] cur_len;

  // A run only replaces the best when it is strictly longer, so on a tie the
  // earliest window is kept. A bad tap and the end-of-sweep close are the
  // same event as far as the open run is concerned.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if ((update && !good) || close) begin
      if (cur_len > best_len) begin
        best_start <= cur_start;
        best_len   <= cur_len;
      end
      cur_len <= '0;
    end else if (update) begin
      if (cur_len == '0) begin
        cur_start <= tap;
      end
      cur_len <= cur_len + LW'(1);
    end
  end

endmodule

// File: rtl/iod_delay_trainer.sv
// -----------------------------------------------------------------------------
// iod_delay_trainer
// Sweeps every tap of a single-bit I/O input delay line, scores each tap
// against a toggling training pattern, finds the longest contiguous window of
// good taps and parks the delay line at its centre.
// Ports:
//   CLK, RST                : lane RX clock, synchronous active-high reset
//   START                   : one-cycle training request (ignored while BUSY)
//   DATA_IN                 : registered lane data
//   DELAY_LINE_OUT_OF_RANGE : delay-line end-of-range flag
//   DELAY_LINE_MOVE/DIRECTION/LOAD : delay-line control pulses
//   BUSY, DONE, LOCKED      : status
//   TAP_OUT, WIN_START, WIN_LEN : training result, valid while DONE
// Optional feature (macro DLY_TRAIN_MAP_EN):
//   TAP_MAP                 : per-tap pass/fail bitmap of the last sweep
// -----------------------------------------------------------------------------
module iod_delay_trainer
  import dly_train_pkg::*;
#(
  parameter int NUM_TAPS      = 128,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CYCLES = 64,
  parameter int MIN_WINDOW    = 4,
  localparam int TW = tap_width(NUM_TAPS),
  localparam int LW = len_width(NUM_TAPS)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          DATA_IN,
  input  logic          DELAY_LINE_OUT_OF_RANGE,
  output logic          DELAY_LINE_MOVE,
  output logic          DELAY_LINE_DIRECTION,
  output logic          DELAY_LINE_LOAD,
  output logic          BUSY,
  output logic          DONE,
  output logic          LOCKED,
  output logic [TW-1:0] TAP_OUT,
  output logic [TW-1:0] WIN_START,
  output logic [LW-1:0] WIN_LEN
`ifdef DLY_TRAIN_MAP_EN
  ,
  output logic [NUM_TAPS-1:0] TAP_MAP
`endif
);

  localparam int CW = 16;

  state_t        state;
  logic [TW-1:0] tap;
  logic [TW-1:0] target;
  logic [CW-1:0] cnt;
  logic          prev_bit;
  logic          err;
  logic          gap;

  logic [TW-1:0] best_start;
  logic [LW-1:0] best_len;
  logic [TW-1:0] target_calc;
  logic          locked_calc;

  // The tracker is driven straight from the state so that its registers
  // change on the edge that ends LOAD, EVAL or FINAL respectively.
  dly_window_tracker #(
    .NUM_TAPS (NUM_TAPS)
  ) u_tracker (
    .clk        (CLK),
    .rst        (RST),
    .clear      (state == ST_LOAD),
    .update     (state == ST_EVAL),
    .good       (~err),
    .close      (state == ST_FINAL),
    .tap        (tap),
    .best_start (best_start),
    .best_len   (best_len)
  );

  // Evaluated in CLOAD, one cycle after FINAL has folded the open run in.
  // best_len>>1 never exceeds NUM_TAPS/2, so it fits a tap index.
  always_comb begin
    locked_calc = (best_len >= LW'(MIN_WINDOW));
    target_calc = locked_calc ? (best_start + TW'(best_len >> 1)) : '0;
  end

  // Main sequencer. All delay-line pulses are registered: a pulse is set on
  // the transition into the cycle where it must be seen and falls back to 0
  // by default the cycle after. The centring walk alternates a MOVE cycle
  // with a gap cycle so the delay line sees clean separate steps.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state                <= ST_IDLE;
      tap                  <= '0;
      target               <= '0;
      cnt                  <= '0;
      prev_bit             <= 1'b0;
      err                  <= 1'b0;
      gap                  <= 1'b0;
      DELAY_LINE_MOVE      <= 1'b0;
      DELAY_LINE_DIRECTION <= 1'b0;
      DELAY_LINE_LOAD      <= 1'b0;
      BUSY                 <= 1'b0;
      DONE                 <= 1'b0;
      LOCKED               <= 1'b0;
      TAP_OUT              <= '0;
      WIN_START            <= '0;
      WIN_LEN              <= '0;
    end else begin
      DELAY_LINE_MOVE      <= 1'b0;
      DELAY_LINE_DIRECTION <= 1'b0;
      DELAY_LINE_LOAD      <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            state           <= ST_LOAD;
            BUSY            <= 1'b1;
            DONE            <= 1'b0;
            DELAY_LINE_LOAD <= 1'b1;
            LOCKED          <= 1'b0;
            TAP_OUT         <= '0;
            WIN_START       <= '0;
            WIN_LEN         <= '0;
          end
        end
        ST_LOAD: begin
          tap   <= '0;
          cnt   <= '0;
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt == CW'(SETTLE_CYCLES - 1)) begin
            cnt   <= '0;
            state <= ST_SAMPLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_SAMPLE: begin
          prev_bit <= DATA_IN;
          if (cnt == '0) begin
            err <= 1'b0;
          end else if (DATA_IN == prev_bit) begin
            err <= 1'b1;
          end
          if (cnt == CW'(SAMPLE_CYCLES - 1)) begin
            cnt   <= '0;
            state <= ST_EVAL;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_EVAL: begin
          if (tap == TW'(NUM_TAPS - 1) || DELAY_LINE_OUT_OF_RANGE) begin
            state <= ST_FINAL;
          end else begin
            state                <= ST_STEP;
            DELAY_LINE_MOVE      <= 1'b1;
            DELAY_LINE_DIRECTION <= 1'b1;
          end
        end
        ST_STEP: begin
          tap   <= tap + TW'(1);
          state <= ST_SETTLE;
        end
        ST_FINAL: begin
          state           <= ST_CLOAD;
          DELAY_LINE_LOAD <= 1'b1;
        end
        ST_CLOAD: begin
          tap       <= '0;
          gap       <= 1'b0;
          target    <= target_calc;
          TAP_OUT   <= target_calc;
          LOCKED    <= locked_calc;
          WIN_START <= best_start;
          WIN_LEN   <= best_len;
          if (target_calc == '0) begin
            state <= ST_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end else begin
            state                <= ST_CSTEP;
            DELAY_LINE_MOVE      <= 1'b1;
            DELAY_LINE_DIRECTION <= 1'b1;
          end
        end
        ST_CSTEP: begin
          if (!gap) begin
            tap <= tap + TW'(1);
            gap <= 1'b1;
          end else if (tap == target) begin
            state <= ST_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end else begin
            gap                  <= 1'b0;
            DELAY_LINE_MOVE      <= 1'b1;
            DELAY_LINE_DIRECTION <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DLY_TRAIN_MAP_EN
  // Pass/fail bitmap: wiped at the start of each sweep, one bit written per
  // evaluated tap, so taps never reached stay 0.
  always_ff @(posedge CLK) begin
    if (RST || state == ST_LOAD) begin
      TAP_MAP <= '0;
    end else if (state == ST_EVAL) begin
      TAP_MAP[tap] <= ~err;
    end
  end
`endif

endmodule

// File: tb/tb_iod_delay_trainer.sv
// -----------------------------------------------------------------------------
// tb_iod_delay_trainer
// Bench for iod_delay_trainer with a behavioural delay-line model. Each run
// pushes its expected result onto a scoreboard queue when START is driven and
// pops it when DONE rises. Builds with or without DLY_TRAIN_MAP_EN.
// -----------------------------------------------------------------------------
module tb_iod_delay_trainer;

  localparam int NT = 16;
  localparam int SC = 2;
  localparam int PC = 4;
  localparam int MW = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       dataIn;
  logic       outOfRange;
  logic       dlMove;
  logic       dlDir;
  logic       dlLoad;
  logic       busy;
  logic       done;
  logic       locked;
  logic [3:0] tapOut;
  logic [3:0] winStart;
  logic [4:0] winLen;
`ifdef DLY_TRAIN_MAP_EN
  logic [NT-1:0] tapMap;
`endif

  typedef struct {
    string tag;
    int    winStart;
    int    winLen;
    int    tapOut;
    int    locked;
    int    busyCycles;
    int    sweepMoves;
    int    centreMoves;
  } expect_t;

  expect_t       scoreboard[$];
  int            assertCount = 0;
  int            failCount   = 0;
  logic [NT-1:0] goodMask    = '0;
  int            oorTap      = -1;
  int            modelTap    = 0;
  logic          toggleBit   = 1'b0;
  int            busyCnt     = 0;
  int            loadCnt     = 0;
  int            sweepMoves  = 0;
  int            centreMoves = 0;
  int            dirErr      = 0;

  always #5 clock = ~clock;

  iod_delay_trainer #(
    .NUM_TAPS      (NT),
    .SETTLE_CYCLES (SC),
    .SAMPLE_CYCLES (PC),
    .MIN_WINDOW    (MW)
  ) dut (
    .CLK                     (clock),
    .RST                     (reset),
    .START                   (start),
    .DATA_IN                 (dataIn),
    .DELAY_LINE_OUT_OF_RANGE (outOfRange),
    .DELAY_LINE_MOVE         (dlMove),
    .DELAY_LINE_DIRECTION    (dlDir),
    .DELAY_LINE_LOAD         (dlLoad),
    .BUSY                    (busy),
    .DONE                    (done),
    .LOCKED                  (locked),
    .TAP_OUT                 (tapOut),
    .WIN_START               (winStart),
    .WIN_LEN                 (winLen)
`ifdef DLY_TRAIN_MAP_EN
    ,
    .TAP_MAP                 (tapMap)
`endif
  );

  // Single comparison point: counts every check, reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One clock of the world outside the DUT: advance to the falling edge,
  // move the delay-line model, tally control activity and present the lane
  // data for the current tap. Good taps toggle, bad taps sit at 0.
  task automatic applyStimulus();
    @(negedge clock);
    if (dlLoad === 1'b1) begin
      modelTap = 0;
    end else if (dlMove === 1'b1 && dlDir === 1'b1 && modelTap < NT - 1) begin
      modelTap++;
    end
    if (busy === 1'b1) busyCnt++;
    if (dlLoad === 1'b1) loadCnt++;
    if (dlMove === 1'b1) begin
      if (loadCnt >= 2) centreMoves++;
      else sweepMoves++;
    end
    if (dlMove !== dlDir) dirErr++;
    toggleBit  = ~toggleBit;
    dataIn     = goodMask[modelTap] ? toggleBit : 1'b0;
    outOfRange = (oorTap >= 0 && modelTap >= oorTap);
  endtask

  // Reference result: scan every run start in the swept range and keep the
  // first longest run.
  function automatic expect_t buildExpect(input string tag);
    expect_t e;
    int n;
    int bestS;
    int bestL;
    int l;
    bestS = 0;
    bestL = 0;
    n = (oorTap >= 0 && oorTap < NT) ? oorTap + 1 : NT;
    for (int s = 0; s < n; s++) begin
      if (goodMask[s] && (s == 0 || !goodMask[s-1])) begin
        l = 0;
        while (s + l < n && goodMask[s+l]) l++;
        if (l > bestL) begin
          bestL = l;
          bestS = s;
        end
      end
    end
    e.tag         = tag;
    e.winStart    = bestS;
    e.winLen      = bestL;
    e.locked      = (bestL >= MW) ? 1 : 0;
    e.tapOut      = (bestL >= MW) ? bestS + bestL / 2 : 0;
    e.busyCycles  = 1 + n * (SC + PC + 1) + (n - 1) + 2 + 2 * e.tapOut;
    e.sweepMoves  = n - 1;
    e.centreMoves = e.tapOut;
    return e;
  endfunction

  task automatic clearCounters();
    busyCnt     = 0;
    loadCnt     = 0;
    sweepMoves  = 0;
    centreMoves = 0;
    dirErr      = 0;
  endtask

  // Full training run: push expectation, pulse START, wait (bounded) for
  // DONE, then pop and compare everything the run should have produced.
  task automatic runScenario(input string tag, input logic [NT-1:0] mask, input int oor);
    expect_t e;
    goodMask = mask;
    oorTap   = oor;
    scoreboard.push_back(buildExpect(tag));
    clearCounters();
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput({tag, "_busy_rise"}, busy, 1);
    checkOutput({tag, "_load_first"}, dlLoad, 1);
    checkOutput({tag, "_done_clear"}, done, 0);
    for (int c = 0; c < 4000 && done !== 1'b1; c++) applyStimulus();
    checkOutput({tag, "_done_reached"}, done, 1);
    e = scoreboard.pop_front();
    checkOutput({e.tag, "_busy_low"}, busy, 0);
    checkOutput({e.tag, "_locked"}, locked, e.locked);
    checkOutput({e.tag, "_tap_out"}, tapOut, e.tapOut);
    checkOutput({e.tag, "_win_start"}, winStart, e.winStart);
    checkOutput({e.tag, "_win_len"}, winLen, e.winLen);
    checkOutput({e.tag, "_busy_cycles"}, busyCnt, e.busyCycles);
    checkOutput({e.tag, "_sweep_moves"}, sweepMoves, e.sweepMoves);
    checkOutput({e.tag, "_centre_moves"}, centreMoves, e.centreMoves);
    checkOutput({e.tag, "_load_pulses"}, loadCnt, 2);
    checkOutput({e.tag, "_parked_tap"}, modelTap, e.tapOut);
    checkOutput({e.tag, "_direction"}, dirErr, 0);
    applyStimulus();
    applyStimulus();
    checkOutput({e.tag, "_done_held"}, done, 1);
    checkOutput({e.tag, "_tap_held"}, tapOut, e.tapOut);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    dataIn     = 1'b0;
    outOfRange = 1'b0;
    $display("[TB] starting iod_delay_trainer bench");
    repeat (3) applyStimulus();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_move", dlMove, 0);
    checkOutput("rst_load", dlLoad, 0);
    checkOutput("rst_dir", dlDir, 0);
    checkOutput("rst_tap_out", tapOut, 0);
    checkOutput("rst_win_len", winLen, 0);

    start = 1'b1;
    applyStimulus();
    reset = 1'b0;
    start = 1'b0;
    applyStimulus();
    checkOutput("rst_beats_start_busy", busy, 0);
    checkOutput("rst_beats_start_load", dlLoad, 0);

    runScenario("s1_all_good", '1, -1);
    runScenario("s2_mid_window", 16'h0FE0, -1);
    runScenario("s3_tie_earliest", 16'h0E1C, -1);
    runScenario("s4_no_good", '0, -1);
    runScenario("s5_out_of_range", 16'hFFC0, 10);

    goodMask = '1;
    oorTap   = -1;
    clearCounters();
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    for (int c = 0; c < 1000 && sweepMoves < 4; c++) applyStimulus();
    checkOutput("s6_reached_tap4", sweepMoves, 4);
    repeat (3) applyStimulus();
    reset = 1'b1;
    applyStimulus();
    checkOutput("s6_rst_busy", busy, 0);
    checkOutput("s6_rst_move", dlMove, 0);
    checkOutput("s6_rst_load", dlLoad, 0);
    checkOutput("s6_rst_done", done, 0);
    reset = 1'b0;
    applyStimulus();
    runScenario("s6_restart", '1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/iod_delay_trainer.md
# iod_delay_trainer

Dynamic delay-line training controller for a single-bit PolarFire I/O input lane. It drives the I/O delay-line control pins (move, direction, load) and consumes the registered input data on the same lane. It sweeps every tap, scores each tap against a toggling training pattern, and finds the longest contiguous window of good taps. It then parks the delay line at the window centre and reports lock to the digitizer's bring-up sequencer.

## Interface
Parameters:
- NUM_TAPS, 128: taps swept, 2..256.
- SETTLE_CYCLES, 8: wait cycles after each load or move before sampling, ≥1.
- SAMPLE_CYCLES, 64: samples scored per tap, ≥2.
- MIN_WINDOW, 4: minimum good-run length required for lock, ≥1.

Ports:
- CLK in 1: lane RX clock, the same clock as the I/O RX_CLK.
- RST in 1: synchronous, active-high reset.
- START in 1: one-cycle request to train; ignored while BUSY.
- DATA_IN in 1: registered lane data (I/O Q output).
- DELAY_LINE_OUT_OF_RANGE in 1: delay-line end-of-range flag.
- DELAY_LINE_MOVE out 1: one-cycle step pulse.
- DELAY_LINE_DIRECTION out 1: step direction; 1 = increment.
- DELAY_LINE_LOAD out 1: one-cycle pulse that reloads the default tap, treated as tap 0.
- BUSY out 1: training in progress.
- DONE out 1: level; training finished; cleared by the next accepted START.
- LOCKED out 1: valid window of at least MIN_WINDOW taps found.
- TAP_OUT out TW: final parked tap, where TW = $clog2(NUM_TAPS).
- WIN_START out TW: first tap of the best window.
- WIN_LEN out LW: length of the best window, where LW = $clog2(NUM_TAPS+1).

## Operation
- The training pattern is DATA_IN alternating each CLK.
- A tap is good when each of its SAMPLE_CYCLES-1 consecutive sample pairs differs. Any equal pair marks the tap bad.
- State machine:
  - IDLE: START → LOAD.
  - LOAD: LOAD pulse; tap=0; clear cur/best trackers → SETTLE.
  - SETTLE: count SETTLE_CYCLES → SAMPLE.
  - SAMPLE: SAMPLE_CYCLES cycles; accumulate the error flag → EVAL.
  - EVAL: update the trackers. If tap==NUM_TAPS-1 or OUT_OF_RANGE is high → FINAL; else → STEP.
  - STEP: MOVE=1, DIRECTION=1; tap++ → SETTLE.
  - FINAL: close the open run. If best_len ≥ MIN_WINDOW: target = best_start + (best_len>>1), LOCKED=1. Otherwise target=0, LOCKED=0. → CLOAD.
  - CLOAD: LOAD pulse; tap=0 → CSTEP.
  - CSTEP: while tap<target, alternate a MOVE pulse cycle with a gap cycle, tap++ on each pulse. When tap==target → DONE.
  - DONE: DONE=1, BUSY=0; START → LOAD.
- Tracker rules:
  - Good tap: if cur_len==0 then cur_start=tap; then cur_len++.
  - Bad tap or FINAL: if cur_len > best_len (strict), best takes cur; then cur_len=0.
  - Ties keep the earliest window.
- All arithmetic is unsigned. Widths never overflow because tap ≤ NUM_TAPS-1.
- DIRECTION is 1 whenever MOVE is high, and 0 otherwise.

## Timing
- Reset values: all outputs 0; state IDLE. Reset does not pulse LOAD.
- BUSY rises the cycle after an accepted START, and falls on entry to DONE.
- The LOAD pulse appears in the first BUSY cycle.
- Total BUSY cycles = 1 + N·(SETTLE_CYCLES+SAMPLE_CYCLES+1) + (N-1) + 2 + 2·target, where N is the number of taps swept.
- TAP_OUT, WIN_START, WIN_LEN and LOCKED are valid while DONE=1 and held until the next START.
- DATA_IN is used only in SAMPLE. The first SAMPLE cycle only seeds the previous-sample register.
- OUT_OF_RANGE is sampled only in EVAL.
- START arriving together with RST: RST wins.
- RST mid-operation: back to IDLE next cycle, with MOVE and LOAD low immediately. The delay-line position is undefined until the next training run.

## Configuration
- DLY_TRAIN_MAP_EN defined:
  - Adds output TAP_MAP [NUM_TAPS-1:0].
  - Bit k is set in EVAL if tap k was good; all bits are cleared in LOAD.
  - Bits for unswept taps stay 0.
- DLY_TRAIN_MAP_EN undefined: the port and its register are absent; all other behaviour is identical.

## Structure
- Package dly_train_pkg holds:
  - the state enum (IDLE, LOAD, SETTLE, SAMPLE, EVAL, STEP, FINAL, CLOAD, CSTEP, DONE);
  - width helper functions for TW and LW.
- Sub-module dly_window_tracker holds the cur/best run registers, the update/close inputs, and the best_start/best_len outputs.
- The FSM and counters stay in the top level.

## Test plan
All scenarios use NUM_TAPS=16, SETTLE_CYCLES=2, SAMPLE_CYCLES=4, MIN_WINDOW=3, with a bench delay-line model.
1. Perfect toggle at every tap → WIN_START=0, WIN_LEN=16, TAP_OUT=8, LOCKED=1; exactly 8 MOVE pulses after the second LOAD.
2. Taps 5..11 good, the rest static → WIN_START=5, WIN_LEN=7, TAP_OUT=8.
3. Taps 2..4 and 9..11 good → earliest window wins: WIN_START=2, WIN_LEN=3, TAP_OUT=3.
4. No good taps → LOCKED=0, TAP_OUT=0, WIN_LEN=0, zero MOVE pulses after CLOAD, DONE=1.
5. Taps 6.. good, OUT_OF_RANGE high at tap 10 → sweep stops after EVAL of tap 10; WIN_START=6, WIN_LEN=5, TAP_OUT=8; 10 STEP pulses total during the sweep.
6. RST during SAMPLE of tap 4 → next cycle BUSY=0, MOVE=LOAD=0; a following START restarts with a LOAD pulse and completes as in scenario 1.
